// File: rtl/cube_frame_sel_if.sv
// Frame-source bus between the game/effect side and the LED cube scanner.
// The master modport is the requester side; the slave modport is cube_frame_sel.
interface cube_frame_sel_if #(
  parameter int N = 8
);
  localparam int NB = N * N * N;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [2:0]    sel;
  logic [NB-1:0] ext_frame;
  logic          frame_sync;
  logic          hold;
  logic [NB-1:0] frame_out;
  logic [2:0]    mode_act;
  logic          frame_upd;
  logic [SW-1:0] step;

  modport master (
    output sel, ext_frame, frame_sync, hold,
    input  frame_out, mode_act, frame_upd, step
  );

  modport slave (
    input  sel, ext_frame, frame_sync, hold,
    output frame_out, mode_act, frame_upd, step
  );
endinterface

// File: rtl/cube_frame_sel.sv
// Double-buffered frame source for the N x N x N LED cube: external frame or one of
// four built-in patterns, reloaded only on the scanner's frame boundary.
module cube_frame_sel #(
  parameter int N        = 8,
  parameter int ANIM_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             rst,
  cube_frame_sel_if.slave  bus
);
  localparam int NB = N * N * N;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(ANIM_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(N - 1);

  logic [NB-1:0] frame_q;
  logic [2:0]    mode_q;
  logic          upd_q;
  logic [SW-1:0] step_q;
  logic [DW-1:0] div_q;

  logic [2:0]    mode_req;
  logic          load;
  logic          mode_chg;
  logic          div_tc;
  logic [SW-1:0] s_pat;
  logic [NB-1:0] pat;

  function automatic logic on_face(input int c);
    return (c == 0) || (c == N - 1);
  endfunction

  assign mode_req = (bus.sel > 3'd4) ? 3'd0 : bus.sel;
  assign load     = bus.frame_sync & ~bus.hold;
  assign mode_chg = load && (mode_req != mode_q);
  assign s_pat    = mode_chg ? '0 : step_q;
  // Step timer counts down; reaching zero marks one animation period.
  assign div_tc   = (div_q == '0);

  always_comb begin
    pat = '0;
    for (int z = 0; z < N; z++) begin
      for (int y = 0; y < N; y++) begin
        for (int x = 0; x < N; x++) begin
          case (mode_req)
            3'd1:    pat[z*N*N + y*N + x] = 1'b1;
            3'd2:    pat[z*N*N + y*N + x] = on_face(x) | on_face(y) | on_face(z);
            3'd3:    pat[z*N*N + y*N + x] = (on_face(x) & on_face(y)) |
                                            (on_face(x) & on_face(z)) |
                                            (on_face(y) & on_face(z));
            3'd4:    pat[z*N*N + y*N + x] = (z == int'(s_pat));
            default: pat[z*N*N + y*N + x] = bus.ext_frame[z*N*N + y*N + x];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      mode_q  <= '0;
      upd_q   <= 1'b0;
      step_q  <= '0;
      div_q   <= DIV_LOAD;
    end else begin
      upd_q <= load;
      if (load) begin
        mode_q  <= mode_req;
        frame_q <= pat;
      end
      // A new mode restarts the animation from layer 0, overriding a same-cycle wrap.
      if (mode_chg) begin
        step_q <= '0;
        div_q  <= DIV_LOAD;
      end else if (div_tc) begin
        div_q  <= DIV_LOAD;
        step_q <= (step_q == STEP_MAX) ? '0 : step_q + SW'(1);
      end else begin
        div_q  <= div_q - DW'(1);
      end
    end
  end

  assign bus.frame_out = frame_q;
  assign bus.mode_act  = mode_q;
  assign bus.frame_upd = upd_q;
  assign bus.step      = step_q;
endmodule

// File: tb/tb_cube_frame_sel.sv
// Directed plus randomized check of cube_frame_sel (N=8, ANIM_DIV=4) against a
// coordinate-rule reference model with an elapsed-cycle view of the animation.
module tb_cube_frame_sel;
  localparam int N  = 8;
  localparam int AD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [511:0] m_frame;
  int           m_mode;
  logic         m_upd;
  int           m_ticks;

  cube_frame_sel_if #(.N(N)) bus ();

  cube_frame_sel #(.N(N), .ANIM_DIV(AD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] ref_pat(input int m, input int s, input logic [511:0] e);
    logic [511:0] r;
    int ne;
    r = '0;
    for (int z = 0; z < N; z++)
      for (int y = 0; y < N; y++)
        for (int x = 0; x < N; x++) begin
          ne = 0;
          if (x == 0 || x == N-1) ne++;
          if (y == 0 || y == N-1) ne++;
          if (z == 0 || z == N-1) ne++;
          case (m)
            1:       r[z*64 + y*8 + x] = 1'b1;
            2:       r[z*64 + y*8 + x] = (ne >= 1);
            3:       r[z*64 + y*8 + x] = (ne >= 2);
            4:       r[z*64 + y*8 + x] = (z == s);
            default: r[z*64 + y*8 + x] = e[z*64 + y*8 + x];
          endcase
        end
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] layer(input int z);
    logic [511:0] r;
    r = '0;
    r[z*64 +: 64] = '1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // One clock: update the model from the inputs present at the edge, then compare.
  task automatic tick();
    int req;
    logic ld, chg;
    @(posedge clk);
    if (rst) begin
      m_frame = '0; m_mode = 0; m_upd = 1'b0; m_ticks = 0;
    end else begin
      req = (bus.sel > 4) ? 0 : int'(bus.sel);
      ld  = bus.frame_sync && !bus.hold;
      chg = ld && (req != m_mode);
      m_upd = ld;
      if (ld) begin
        m_frame = ref_pat(req, chg ? 0 : (m_ticks / AD) % N, bus.ext_frame);
        m_mode  = req;
      end
      m_ticks = chg ? 0 : m_ticks + 1;
    end
    #1;
    check("frame_out", bus.frame_out, m_frame);
    check("mode_act", 512'(bus.mode_act), 512'(m_mode));
    check("frame_upd", 512'(bus.frame_upd), 512'(m_upd));
    check("step", 512'(bus.step), 512'((m_ticks / AD) % N));
  endtask

  task automatic sync_tick();
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
  endtask

  initial begin
    logic [511:0] a, b;
    int gap;
    bus.sel = 3'd1; bus.ext_frame = '0; bus.frame_sync = 1'b0; bus.hold = 1'b0;
    m_frame = '0; m_mode = 0; m_upd = 1'b0; m_ticks = 0;

    // 1: reset, then first load shows all-on
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_frame", bus.frame_out, '0);
    check("rst_mode", 512'(bus.mode_act), 512'(0));
    sync_tick();
    check("allon_frame", bus.frame_out, {512{1'b1}});
    check("allon_upd", 512'(bus.frame_upd), 512'(1));
    check("allon_mode", 512'(bus.mode_act), 512'(1));
    tick();
    check("upd_pulse", 512'(bus.frame_upd), 512'(0));

    // 2: shell
    bus.sel = 3'd2;
    sync_tick();
    check("shell_z0", 512'(bus.frame_out[0 +: 64]), 512'({64{1'b1}}));
    check("shell_z7", 512'(bus.frame_out[448 +: 64]), 512'({64{1'b1}}));
    check("shell_z3", 512'(bus.frame_out[192 +: 64]), 512'(64'hFF81_8181_8181_81FF));

    // 3: wireframe
    bus.sel = 3'd3;
    sync_tick();
    check("wire_z0", 512'(bus.frame_out[0 +: 64]), 512'(64'hFF81_8181_8181_81FF));
    check("wire_z3", 512'(bus.frame_out[192 +: 64]), 512'(64'h8100_0000_0000_0081));

    // 4: walking layer; after the restart, syncs land one step further each time
    bus.sel = 3'd4;
    sync_tick();
    check("walk_k0", bus.frame_out, layer(0));
    for (int k = 1; k <= 8; k++) begin
      gap = (k == 1) ? 5 : 4;
      for (int i = 0; i < gap - 1; i++) tick();
      sync_tick();
      check($sformatf("walk_k%0d", k), bus.frame_out, layer(k % 8));
    end
    bus.sel = 3'd1;
    sync_tick();
    bus.sel = 3'd4;
    for (int i = 0; i < 6; i++) tick();
    sync_tick();
    check("walk_restart", bus.frame_out, layer(0));

    // 5: external frame, no reload without sync, hold freezes
    a = rand512(); b = rand512();
    bus.sel = 3'd0; bus.ext_frame = a;
    sync_tick();
    check("ext_a", bus.frame_out, a);
    bus.ext_frame = b;
    tick(); tick();
    check("ext_nosync", bus.frame_out, a);
    bus.hold = 1'b1;
    sync_tick();
    check("hold_frame", bus.frame_out, a);
    check("hold_upd", 512'(bus.frame_upd), 512'(0));
    bus.hold = 1'b0;

    // 6: out-of-range sel maps to external; reset blanks right after a load
    bus.sel = 3'd6;
    sync_tick();
    check("sel6_mode", 512'(bus.mode_act), 512'(0));
    check("sel6_frame", bus.frame_out, b);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_blank", bus.frame_out, '0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) bus.sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.ext_frame = rand512();
      bus.frame_sync = ($urandom_range(0, 2) == 0);
      bus.hold = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b0; bus.frame_sync = 1'b0; bus.hold = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
